mod_shift_mul_seq: RTL and testbench

- Sequential modular power-of-two multiplier: computes oData = (iData * 2^iShift) mod iQ, with the shift amount selected per operation at run time.
- Parametrised successor of the fixed-×4 modular register. It generalises width and shift amount, adds a valid/ready handshake on both sides, detects illegal operands, and supports stall and abort.
- Sits between operand staging and the modular arithmetic datapath in the unary/modular compute chain.

---
 rtl/mod_shift_mul_seq.sv | 135 +++++++++++++
 tb/tb_mod_shift_mul_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_shift_mul_seq.sv
// Sequential modular power-of-two multiplier: oData = (iData * 2^iShift) mod iQ.
// Valid/ready on both sides; one modular doubling per enabled cycle, with stall and abort.
module mod_shift_mul_seq #(
  parameter int BITWIDTH = 8,
  parameter int SHW      = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iQ,
  input  logic [SHW-1:0]      iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oErr
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t              r_state;
  logic [BITWIDTH-1:0] r_acc;
  logic [BITWIDTH-1:0] r_q;
  logic [SHW-1:0]      r_cnt;
  logic                r_err;
  logic                r_oReady;
  logic                r_oValid;
  logic [BITWIDTH-1:0] r_oData;
  logic                r_oErr;

  logic [BITWIDTH-1:0] w_dblLo;
  logic                w_ge;
  logic [BITWIDTH-1:0] w_sub;
  logic [BITWIDTH-1:0] w_next;
  logic                w_illegal;
  logic                w_lastStep;

  // The doubled value is BITWIDTH+1 bits wide; its carry-out is acc's MSB, so the
  // comparison uses it directly and only the low bits of the difference are kept,
  // which is exact because acc < q guarantees the reduced result fits.
  assign w_dblLo    = {r_acc[BITWIDTH-2:0], 1'b0};
  assign w_ge       = r_acc[BITWIDTH-1] | (w_dblLo >= r_q);
  assign w_sub      = w_dblLo - r_q;
  assign w_next     = w_ge ? w_sub : w_dblLo;
  assign w_illegal  = (iQ == '0) || (iData >= iQ);
  assign w_lastStep = (r_cnt == CNT_ONE);

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_oReady <= 1'b1;
      r_oValid <= 1'b0;
      r_oData  <= '0;
      r_oErr   <= 1'b0;
    end else if (iEn) begin
      case (r_state)
        IDLE: begin
          if (iValid) begin
            r_q      <= iQ;
            r_cnt    <= iShift;
            r_oReady <= 1'b0;
            if (w_illegal) begin
              r_acc    <= '0;
              r_err    <= 1'b1;
              r_state  <= DONE;
              r_oValid <= 1'b1;
              r_oData  <= '0;
              r_oErr   <= 1'b1;
            end else if (iShift == '0) begin
              r_acc    <= iData;
              r_err    <= 1'b0;
              r_state  <= DONE;
              r_oValid <= 1'b1;
              r_oData  <= iData;
              r_oErr   <= 1'b0;
            end else begin
              r_acc   <= iData;
              r_err   <= 1'b0;
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          r_acc <= w_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_lastStep) begin
            r_state  <= DONE;
            r_oValid <= 1'b1;
            r_oData  <= w_next;
            r_oErr   <= r_err;
          end
        end

        DONE: begin
          // Result and error stay put until the consumer takes them.
          if (iReady) begin
            r_state  <= IDLE;
            r_oReady <= 1'b1;
            r_oValid <= 1'b0;
            r_oData  <= '0;
            r_oErr   <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_oReady <= 1'b1;
          r_oValid <= 1'b0;
          r_oData  <= '0;
          r_oErr   <= 1'b0;
        end
      endcase
    end
  end

  assign oReady = r_oReady;
  assign oValid = r_oValid;
  assign oData  = r_oData;
  assign oErr   = r_oErr;

endmodule

// File: tb/tb_mod_shift_mul_seq.sv
// Directed, table-driven bench for mod_shift_mul_seq with hand-computed results,
// plus hand-written sequences for backpressure, stall, abort and reset.
module tb_mod_shift_mul_seq;

  logic       iClk = 1'b0;
  logic       iRst, iEn, iClr, iValid, iReady;
  logic [7:0] iData, iQ;
  logic [3:0] iShift;
  logic       oReady, oValid, oErr;
  logic [7:0] oData;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] q;
    logic [3:0] shift;
    logic [7:0] expData;
    logic       expErr;
    int         expLat;
    string      name;
  } vec_t;

  vec_t vecs[16];

  mod_shift_mul_seq #(.BITWIDTH(8), .SHW(4)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
    .iValid(iValid), .oReady(oReady),
    .iData(iData), .iQ(iQ), .iShift(iShift),
    .oValid(oValid), .iReady(iReady),
    .oData(oData), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " oReady idle"}, int'(oReady), 1);
    checkOutput({name, " oValid idle"}, int'(oValid), 0);
    checkOutput({name, " oData idle"}, int'(oData), 0);
  endtask

  // Presents one operand for a single cycle and returns the number of cycles
  // from the accepting edge until oValid is observed (bounded at 40).
  task automatic acceptAndWait(input logic [7:0] d, input logic [7:0] q,
                               input logic [3:0] sh, input string name,
                               output int lat);
    checkOutput({name, " oReady before accept"}, int'(oReady), 1);
    iData  = d;
    iQ     = q;
    iShift = sh;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iData  = 8'hAA;
    iQ     = 8'h55;
    iShift = 4'h7;
    lat = 1;
    while (!oValid && lat < 40) begin
      checkOutput({name, " oReady busy"}, int'(oReady), 0);
      tick();
      lat++;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    acceptAndWait(v.data, v.q, v.shift, v.name, lat);
    checkOutput({v.name, " latency"}, lat, v.expLat);
    checkOutput({v.name, " oValid"}, int'(oValid), 1);
    checkOutput({v.name, " oReady low"}, int'(oReady), 0);
    checkOutput({v.name, " oData"}, int'(oData), int'(v.expData));
    checkOutput({v.name, " oErr"}, int'(oErr), int'(v.expErr));
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkIdle(v.name);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{8'd10,  8'd23,  4'd2,  8'd17,  1'b0, 3,  "basic 10*4%23"};
    vecs[1]  = '{8'd10,  8'd22,  4'd2,  8'd18,  1'b0, 3,  "sweep q22"};
    vecs[2]  = '{8'd10,  8'd21,  4'd2,  8'd19,  1'b0, 3,  "sweep q21"};
    vecs[3]  = '{8'd10,  8'd20,  4'd2,  8'd0,   1'b0, 3,  "sweep q20"};
    vecs[4]  = '{8'd10,  8'd19,  4'd2,  8'd2,   1'b0, 3,  "sweep q19"};
    vecs[5]  = '{8'd10,  8'd18,  4'd2,  8'd4,   1'b0, 3,  "sweep q18"};
    vecs[6]  = '{8'd10,  8'd17,  4'd2,  8'd6,   1'b0, 3,  "sweep q17"};
    vecs[7]  = '{8'd10,  8'd16,  4'd2,  8'd8,   1'b0, 3,  "sweep q16"};
    vecs[8]  = '{8'd10,  8'd15,  4'd2,  8'd10,  1'b0, 3,  "sweep q15"};
    vecs[9]  = '{8'd10,  8'd14,  4'd2,  8'd12,  1'b0, 3,  "sweep q14"};
    vecs[10] = '{8'd10,  8'd23,  4'd0,  8'd10,  1'b0, 1,  "shift0"};
    vecs[11] = '{8'd200, 8'd251, 4'd1,  8'd149, 1'b0, 2,  "overflow 200*2%251"};
    vecs[12] = '{8'd1,   8'd255, 4'd15, 8'd128, 1'b0, 16, "max shift 2^15%255"};
    vecs[13] = '{8'd23,  8'd23,  4'd2,  8'd0,   1'b1, 1,  "illegal d==q"};
    vecs[14] = '{8'd0,   8'd0,   4'd3,  8'd0,   1'b1, 1,  "illegal q==0"};
    vecs[15] = '{8'd250, 8'd251, 4'd3,  8'd243, 1'b0, 4,  "legal after err 250*8%251"};

    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iValid = 1'b0; iReady = 1'b0;
    iData = '0; iQ = '0; iShift = '0;
    tick();
    tick();
    iRst = 1'b0;
    checkIdle("reset");
    checkOutput("reset oErr", int'(oErr), 0);

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

    // Backpressure: result must stay put while iReady is low.
    acceptAndWait(8'd10, 8'd23, 4'd2, "backpressure", lat);
    checkOutput("backpressure latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("backpressure oValid held", int'(oValid), 1);
      checkOutput("backpressure oData held", int'(oData), 17);
    end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkIdle("backpressure release");

    // iEn low in IDLE must not accept an operand.
    iEn = 1'b0; iValid = 1'b1; iData = 8'd3; iQ = 8'd7; iShift = 4'd1;
    tick();
    tick();
    iValid = 1'b0; iEn = 1'b1;
    checkIdle("no accept while disabled");

    // Stall three cycles mid-RUN: latency grows by three, result unchanged.
    checkOutput("stall oReady before accept", int'(oReady), 1);
    iData = 8'd10; iQ = 8'd23; iShift = 4'd2; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    lat = 1;
    iEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat++;
      checkOutput("stall oValid low", int'(oValid), 0);
      checkOutput("stall oReady low", int'(oReady), 0);
    end
    iEn = 1'b1;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("stall latency", lat, 6);
    checkOutput("stall oData", int'(oData), 17);
    checkOutput("stall oErr", int'(oErr), 0);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checkIdle("stall release");

    // Abort mid-RUN.
    iData = 8'd1; iQ = 8'd255; iShift = 4'd10; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    checkOutput("abort in RUN", int'(oReady), 0);
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    checkIdle("abort");
    checkOutput("abort oErr", int'(oErr), 0);

    // Reset while DONE discards the pending result.
    acceptAndWait(8'd5, 8'd7, 4'd1, "reset in done", lat);
    checkOutput("reset in done oValid", int'(oValid), 1);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    checkIdle("reset in done");

    applyStimulus('{8'd10, 8'd23, 4'd2, 8'd17, 1'b0, 3, "after abort/reset"});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
